// File: rtl/herzel_pkg.sv
// Shared definitions for the Goertzel (Herzel) front-end: feeder state
// encoding, the 32.32 fixed-point format and the sample alignment shift.
package herzel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } feed_state_t;

    // Fraction bits of the core's signed 32.32 input format.
    localparam int Q_FRAC = 32;

    // Left shift that moves a Q1.(sw-1) sample's binary point onto bit Q_FRAC.
    function automatic int q_shift(input int sw);
        return Q_FRAC + 1 - sw;
    endfunction

endpackage

// File: rtl/herzel_feeder_fifo.sv
// Single-clock sample FIFO in front of the Goertzel core. Power-of-two depth
// so the read/write pointers wrap naturally; fill tracks occupancy 0..DEPTH.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (fill == '0);
    assign full    = (fill == FW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Sample storage; contents need no reset since fill gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps fill steady.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/herzel_feeder.sv
// Upstream feeder for the Goertzel core: buffers Q1.(SW-1) samples, clears
// the core on each start, streams ns samples as signed 32.32 with a per-sample
// enable, then returns the core's 16.16 magnitude (or flags a timeout).
module herzel_feeder #(
    parameter int SW    = 16,
    parameter int DEPTH = 16,
    parameter int TMO   = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [SW-1:0] s_data,
    input  logic                 start,
    input  logic [31:0]          ns_i,
    output logic                 busy,
    output logic                 g_rstn_o,
    output logic                 g_en_o,
    output logic signed [63:0]   g_data_o,
    input  logic                 g_valid_i,
    input  logic [31:0]          g_mag_i,
    output logic [31:0]          mag_o,
    output logic                 done,
    output logic                 err
);

    import herzel_pkg::*;

    localparam int SHIFT  = q_shift(SW);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int TMO_W  = $clog2(TMO) + 1;

    feed_state_t        state;
    logic [31:0]        ns_lat;
    logic [31:0]        cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [SW-1:0]      fifo_rdata;
    logic [FILL_W-1:0]  fifo_fill;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_p0;
    logic               pop_p0;

    // Sign-extend a Q1.(SW-1) sample and align its binary point to 32.32.
    function automatic logic signed [63:0] to_q32(input logic signed [SW-1:0] s);
        logic signed [63:0] ext;
        ext = {{(64-SW){s[SW-1]}}, s};
        return ext <<< SHIFT;
    endfunction

    assign s_ready = rstn && (fifo_fill != FILL_W'(DEPTH));
    assign push_p0 = s_valid && rstn && !fifo_full;
    assign pop_p0  = (state == ST_FEED) && !fifo_empty && (cnt < ns_lat);
    assign busy    = (state != ST_IDLE);

    sync_fifo #(
        .W     (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_p0),
        .pop   (pop_p0),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .fill  (fifo_fill),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Frame sequencer: clear core, stream samples, await magnitude or timeout.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            ns_lat   <= '0;
            cnt      <= '0;
            tmo_cnt  <= '0;
            g_rstn_o <= 1'b0;
            g_en_o   <= 1'b0;
            g_data_o <= '0;
            mag_o    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            g_rstn_o <= 1'b1;
            g_en_o   <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (ns_i == '0) begin
                            // The core would never leave its CALC state on ns=0.
                            err <= 1'b1;
                        end else begin
                            ns_lat   <= ns_i;
                            cnt      <= '0;
                            err      <= 1'b0;
                            g_rstn_o <= 1'b0;
                            state    <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (pop_p0) begin
                        g_en_o   <= 1'b1;
                        g_data_o <= to_q32(fifo_rdata);
                        cnt      <= cnt + 32'd1;
                    end else if (cnt == ns_lat) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (g_valid_i) begin
                        mag_o <= g_mag_i;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (tmo_cnt == TMO_W'(TMO - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_herzel_feeder.sv
// Directed bench for herzel_feeder: cycle-exact frame timing, FIFO
// backpressure, underrun gaps, ns boundaries, WAIT timeout and mid-frame reset.
module tb_herzel_feeder;

    localparam int SW    = 16;
    localparam int DEPTH = 16;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_data;
    logic          start;
    logic [31:0]   ns_i;
    logic          busy;
    logic          g_rstn_o;
    logic          g_en_o;
    logic [63:0]   g_data_o;
    logic          g_valid_i;
    logic [31:0]   g_mag_i;
    logic [31:0]   mag_o;
    logic          done;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] en_q [$];
    int          adj_cnt  = 0;
    int          done_cnt = 0;
    logic        prev_en  = 1'b0;

    int          base;
    int          acc;
    int          adj0;
    int          dc0;
    logic [15:0] ur_in  [4];
    logic [63:0] ur_exp [4];
    logic [63:0] fs_exp [6];

    always #5 clk = ~clk;

    herzel_feeder #(
        .SW    (SW),
        .DEPTH (DEPTH),
        .TMO   (TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .start     (start),
        .ns_i      (ns_i),
        .busy      (busy),
        .g_rstn_o  (g_rstn_o),
        .g_en_o    (g_en_o),
        .g_data_o  (g_data_o),
        .g_valid_i (g_valid_i),
        .g_mag_i   (g_mag_i),
        .mag_o     (mag_o),
        .done      (done),
        .err       (err)
    );

    // Record every enabled sample, adjacent enable pairs and done pulses.
    always @(negedge clk) begin
        if (g_en_o) en_q.push_back(g_data_o);
        if (g_en_o && prev_en) adj_cnt <= adj_cnt + 1;
        prev_en <= g_en_o;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [15:0] d);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [31:0] mag);
        int n;
        n = 0;
        g_valid_i = 1'b1;
        g_mag_i   = mag;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        g_valid_i = 1'b0;
        chk("frame_done", {63'd0, done}, 64'd1);
        chk("frame_mag", {32'd0, mag_o}, {32'd0, mag});
        tick();
    endtask

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0;
        ns_i = '0; g_valid_i = 1'b0; g_mag_i = '0;
        ur_in[0] = 16'h0123; ur_exp[0] = 64'h0000_0000_0246_0000;
        ur_in[1] = 16'h7FFF; ur_exp[1] = 64'h0000_0000_FFFE_0000;
        ur_in[2] = 16'hFFFF; ur_exp[2] = 64'hFFFF_FFFF_FFFE_0000;
        ur_in[3] = 16'h0002; ur_exp[3] = 64'h0000_0000_0004_0000;
        fs_exp[0] = 64'h0000_0000_0022_0000;
        fs_exp[1] = 64'h0000_0000_0024_0000;
        fs_exp[2] = 64'h0000_0000_0026_0000;
        fs_exp[3] = 64'h0000_0000_0028_0000;
        fs_exp[4] = 64'h0000_0000_002A_0000;
        fs_exp[5] = 64'h0000_0000_002C_0000;

        // Reset values
        repeat (3) tick();
        chk("rst_g_rstn", {63'd0, g_rstn_o}, 64'd0);
        chk("rst_g_en", {63'd0, g_en_o}, 64'd0);
        chk("rst_g_data", g_data_o, 64'd0);
        chk("rst_mag", {32'd0, mag_o}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        rstn = 1'b1;
        tick();
        chk("g_rstn_rise", {63'd0, g_rstn_o}, 64'd1);
        chk("s_ready_up", {63'd0, s_ready}, 64'd1);

        // Basic frame: 8 x 0x4000, cycle-exact
        s_valid = 1'b1; s_data = 16'h4000;
        repeat (8) tick();
        s_valid = 1'b0;
        start = 1'b1; ns_i = 32'd8;
        tick();
        start = 1'b0;
        chk("c1_g_rstn", {63'd0, g_rstn_o}, 64'd0);
        chk("c1_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("c2_g_rstn", {63'd0, g_rstn_o}, 64'd1);
        chk("c2_en", {63'd0, g_en_o}, 64'd0);
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk($sformatf("c%0d_en", c), {63'd0, g_en_o}, 64'd1);
            chk($sformatf("c%0d_data", c), g_data_o, 64'h0000_0000_8000_0000);
        end
        tick();
        chk("c11_en", {63'd0, g_en_o}, 64'd0);
        tick();
        chk("c12_done", {63'd0, done}, 64'd0);
        g_valid_i = 1'b1; g_mag_i = 32'h0001_2000;
        tick();
        g_valid_i = 1'b0;
        chk("basic_done", {63'd0, done}, 64'd1);
        chk("basic_mag", {32'd0, mag_o}, 64'h0000_0000_0001_2000);
        chk("basic_err", {63'd0, err}, 64'd0);
        tick();
        chk("basic_done_1cyc", {63'd0, done}, 64'd0);
        chk("basic_idle", {63'd0, busy}, 64'd0);
        chk("basic_g_rstn_idle", {63'd0, g_rstn_o}, 64'd1);

        // FIFO full / backpressure, then a 20-sample frame
        acc = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 16'(i + 1);
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        chk("fifo_accepted", 64'(acc), 64'd16);
        chk("fifo_full_ready", {63'd0, s_ready}, 64'd0);
        base = en_q.size();
        start = 1'b1; ns_i = 32'd20;
        tick();
        start = 1'b0;
        for (int i = 17; i <= 20; i++) push1(16'(i));
        finish_frame(32'h0000_0BAD);
        chk("bp_count", 64'(en_q.size() - base), 64'd20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("bp_data%0d", i), en_q[base + i], 64'(i + 1) * 64'd131072);

        // ns = 0 rejected
        start = 1'b1; ns_i = 32'd0;
        tick();
        start = 1'b0;
        chk("ns0_err", {63'd0, err}, 64'd1);
        chk("ns0_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("ns0_busy_hold", {63'd0, busy}, 64'd0);

        // Underrun: one sample every 3 cycles
        base = en_q.size();
        adj0 = adj_cnt;
        start = 1'b1; ns_i = 32'd4;
        tick();
        start = 1'b0;
        chk("err_cleared", {63'd0, err}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = ur_in[i];
            tick();
            s_valid = 1'b0;
            tick();
            tick();
        end
        finish_frame(32'h0000_1111);
        chk("ur_count", 64'(en_q.size() - base), 64'd4);
        chk("ur_isolated", 64'(adj_cnt - adj0), 64'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ur_data%0d", i), en_q[base + i], ur_exp[i]);

        // ns = 1 with most-negative sample
        push1(16'h8000);
        base = en_q.size();
        start = 1'b1; ns_i = 32'd1;
        tick();
        start = 1'b0;
        finish_frame(32'h0000_2222);
        chk("ns1_count", 64'(en_q.size() - base), 64'd1);
        chk("neg_data", en_q[base], 64'hFFFF_FFFF_0000_0000);

        // start during FEED is ignored
        for (int k = 1; k <= 6; k++) push1(16'h0010 + 16'(k));
        base = en_q.size();
        start = 1'b1; ns_i = 32'd4;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; ns_i = 32'd2;
        tick();
        start = 1'b0;
        chk("feed_start_busy", {63'd0, busy}, 64'd1);
        finish_frame(32'h0000_3333);
        chk("feed_start_count", 64'(en_q.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fs_data%0d", i), en_q[base + i], fs_exp[i]);
        base = en_q.size();
        start = 1'b1; ns_i = 32'd2;
        tick();
        start = 1'b0;
        finish_frame(32'h0000_4444);
        chk("fs_rest_count", 64'(en_q.size() - base), 64'd2);
        chk("fs_rest0", en_q[base], fs_exp[4]);
        chk("fs_rest1", en_q[base + 1], fs_exp[5]);

        // WAIT timeout: no g_valid_i
        push1(16'h0100);
        base = en_q.size();
        start = 1'b1; ns_i = 32'd1;
        tick();
        start = 1'b0;
        repeat (66) tick();
        chk("tmo_c67_done", {63'd0, done}, 64'd0);
        chk("tmo_c67_err", {63'd0, err}, 64'd0);
        chk("tmo_c67_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("tmo_done", {63'd0, done}, 64'd1);
        chk("tmo_err", {63'd0, err}, 64'd1);
        chk("tmo_mag_kept", {32'd0, mag_o}, 64'h0000_0000_0000_4444);
        chk("tmo_data", en_q[base], 64'h0000_0000_0200_0000);
        tick();
        chk("tmo_idle", {63'd0, busy}, 64'd0);
        chk("tmo_err_sticky", {63'd0, err}, 64'd1);

        // Reset in the middle of FEED
        for (int k = 0; k < 8; k++) push1(16'h0200 + 16'(k));
        dc0 = done_cnt;
        base = en_q.size();
        start = 1'b1; ns_i = 32'd8;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_en", {63'd0, g_en_o}, 64'd1);
        rstn = 1'b0;
        tick();
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_g_rstn", {63'd0, g_rstn_o}, 64'd0);
        chk("mid_rst_en", {63'd0, g_en_o}, 64'd0);
        chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
        rstn = 1'b1;
        tick();
        chk("post_rst_g_rstn", {63'd0, g_rstn_o}, 64'd1);
        chk("post_rst_err", {63'd0, err}, 64'd0);
        chk("mid_rst_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("mid_rst_pulses", 64'(en_q.size() - base), 64'd3);
        push1(16'h0300);
        push1(16'h0301);
        base = en_q.size();
        start = 1'b1; ns_i = 32'd2;
        tick();
        start = 1'b0;
        finish_frame(32'h0000_5555);
        chk("after_rst_count", 64'(en_q.size() - base), 64'd2);
        chk("after_rst_d0", en_q[base], 64'h0000_0000_0600_0000);
        chk("after_rst_d1", en_q[base + 1], 64'h0000_0000_0602_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/herzel_feeder.md
# herzel_feeder

Upstream stage of the Goertzel core (`Herzel`).
- Accepts a stream of signed ADC samples over a valid/ready handshake and buffers them in a small FIFO.
- Converts each sample from Q1.(SW-1) to signed 32.32.
- On each `start`, clears the core and feeds it exactly `ns_i` samples with per-sample `en`.
- Waits for the core's `valid`, then returns the 16.16 magnitude with a done pulse.

## Interface
- `SW`, 16, sample width; the sample is signed Q1.(SW-1). Legal range 2..32.
- `DEPTH`, 16, FIFO depth in samples; must be a power of two, ≥ 2.
- `TMO`, 64, maximum cycles in WAIT before `err` is raised.

Clocking and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  synchronous active-low reset.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  FIFO can accept a sample; equals `rstn && (fill != DEPTH)`.
- `s_data`  in  SW  signed sample.
- `start`  in  1  single-cycle request to process one frame.
- `ns_i`  in  32  frame length in samples; latched on an accepted `start`.
- `busy`  out  1  high whenever FSM ≠ IDLE.
- `g_rstn_o`  out  1  drives core `rstn`; low clears the core.
- `g_en_o`  out  1  drives core `en`; high only in cycles carrying a sample.
- `g_data_o`  out  64  drives core `data_i`; signed 32.32.
- `g_valid_i`  in  1  core `valid`.
- `g_mag_i`  in  32  core `data_o`; unsigned 16.16.
- `mag_o`  out  32  magnitude captured at frame end.
- `done`  out  1  one-cycle pulse when `mag_o` updates.
- `err`  out  1  sticky flag for bad `ns_i` or WAIT timeout; cleared by reset or by the next accepted `start`.

## Operation
- **Conversion:** `g_data_o` is `s_data` sign-extended and shifted left by 33-SW. For SW=16 this is a shift of 17; for example 0x4000 (0.5) maps to 0x0000_0000_8000_0000.
- **FIFO:**
  - Push when `s_valid && s_ready`, in any state.
  - Pop only in FEED, when the FIFO is not empty and `cnt < ns_lat`.
  - A push and a pop in the same cycle leave `fill` unchanged.
  - Pointers wrap modulo DEPTH.
  - Pushes are not allowed at full, even if a pop occurs in the same cycle.
- **FSM states:** IDLE, CLEAR, FEED, WAIT, DONE.
  - **IDLE:**
    - `start && ns_i != 0`: latch `ns_lat`, clear `cnt` and `err`, go to CLEAR.
    - `start && ns_i == 0`: set `err` and stay in IDLE. This rejection exists because the core never leaves CALC when ns=0.
    - `start` while busy is ignored.
  - **CLEAR:** `g_rstn_o` = 0 for exactly one cycle, then go to FEED.
  - **FEED:**
    - Each pop registers `g_en_o` = 1 with the converted data and increments `cnt`.
    - In cycles with no pop, `g_en_o` = 0 and `g_data_o` holds its value.
    - When `cnt` reaches `ns_lat` after the last pop, go to WAIT.
  - **WAIT:**
    - `g_en_o` = 0 and a timeout counter runs.
    - `g_valid_i` = 1: capture `g_mag_i` into `mag_o`, go to DONE.
    - Counter reaches TMO: set `err`, go to DONE with `mag_o` unchanged.
  - **DONE:** `done` = 1 for one cycle, then go to IDLE.
- **`g_rstn_o` level outside CLEAR:** stays 1 from CLEAR onward and remains 1 in IDLE, so the core's output stays valid until the next frame.
- **Reset:**
  - Register reset values: `g_rstn_o` 0, `g_en_o` 0, `g_data_o` 0, `mag_o` 0, `done` 0, `err` 0, `busy` 0.
  - `s_ready` is 0 while `rstn` is low and the FIFO is emptied.
  - Reset mid-frame discards the frame and buffered samples; no `done` is produced.
  - `g_rstn_o` rises to 1 on the first clock with `rstn` high.

## Timing
- Cycle numbering: edge 0 samples `start`.
- Cycle 1: `g_rstn_o` = 0 (CLEAR).
- Cycle 2: first pop is possible. Cycle 3: first `g_en_o` = 1.
- With the FIFO pre-filled with ≥ ns samples, `g_en_o` is high for ns consecutive cycles (3..ns+2).
- WAIT is entered the cycle after the last `g_en_o`.
- `done` is asserted the cycle after `g_valid_i` is seen; `mag_o` is valid in the same cycle as `done`.
- The core needs about 7 cycles after the last sample, so the TMO=64 default has margin.
- Throughput: one sample per cycle; an underrunning FIFO only inserts gaps in `g_en_o`.

## Structure
- Shared package `herzel_pkg` holds:
  - the feeder state enum;
  - `Q_FRAC = 32`, the 32.32 fraction bits;
  - the function computing the shift 33-SW.
- Natural sub-module `sync_fifo` (parameters W, DEPTH): single clock, synchronous active-low reset, outputs `fill`, `empty` and `full`.
- FSM, counters and conversion live in `herzel_feeder`.

## Test plan
- **Basic frame:** reset, push 8 samples 0x4000, `start` with ns=8 → `g_rstn_o` low at cycle 1; `g_en_o` high in cycles 3..10 with `g_data_o` = 0x0000_0000_8000_0000; model core asserts `g_valid_i` with `g_mag_i` = 0x0001_2000 → `done` pulses and `mag_o` = 0x0001_2000.
- **FIFO full/backpressure:** hold `s_valid` for 20 cycles with no `start` → exactly 16 accepted and `s_ready` low after the 16th; then `start` with ns=20 → 20 `g_en_o` pulses in sample order with no loss or duplication.
- **Underrun:** `start` ns=4 on an empty FIFO, feed one sample every 3 cycles → `g_en_o` has 4 isolated pulses and the data matches.
- **Boundaries:**
  - ns=0 → `err` = 1, `busy` stays 0.
  - ns=1 → one `g_en_o` pulse.
  - `start` during FEED → ignored and `cnt` unaffected.
  - Negative sample 0x8000 → `g_data_o` = 0xFFFF_FFFF_0000_0000.
- **Timeout:** `g_valid_i` never asserted → `err` = 1 and `done` after 64 WAIT cycles; `mag_o` unchanged.
- **Reset mid-FEED:** assert `rstn` = 0 after 3 of 8 samples → next cycle `busy` 0, `g_rstn_o` 0, FIFO empty, no `done`; a new frame then runs correctly.
